// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle for uart_tx_fifo: write handshake plus transmitter status.
// Ports: tx_valid/tx_data/tx_ready form the write handshake; fifo_level, busy,
//        tx_done and uart_txd report queue depth, frame activity and the line.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                        tx_valid;
  logic [DATA_BITS-1:0]        tx_data;
  logic                        tx_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        busy;
  logic                        tx_done;
  logic                        uart_txd;

  // master: the producer writing words; slave: the transmitter.
  modport master (
    output tx_valid, output tx_data,
    input  tx_ready, input fifo_level, input busy, input tx_done, input uart_txd
  );
  modport slave (
    input  tx_valid, input tx_data,
    output tx_ready, output fifo_level, output busy, output tx_done, output uart_txd
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: queued UART transmitter, DATA_BITS LSB first, optional parity, 1/2 stop bits.
// Latency: start bit on the line 1 clk after IDLE sees a queued word (2 clks after a write into an empty FIFO).
// Backpressure: tx_ready low while FIFO_DEPTH words are queued; decoded from registered level only.
// Ports: sys_clk/sys_rst (async, active high); bus = write handshake + level/busy/tx_done/uart_txd.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic           sys_clk,
  input logic           sys_rst,
  uart_tx_fifo_if.slave bus
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  // Counter must reach the full stop period, which may span two bit times.
  localparam int CW      = $clog2(STOP_BITS * BPS_CNT + 1);
  localparam int BW      = $clog2(DATA_BITS + 1);
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * BPS_CNT - 1);
  // tx_done is registered, so it is armed one clock early to land on the last stop clock.
  localparam logic [CW-1:0] STOP_DONE = CW'(STOP_BITS * BPS_CNT - 2);
  localparam logic [BW-1:0] DBIT_LAST = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if (BPS_CNT < 2) begin : g_bad_bps
    $error("uart_tx_fifo: CLK_FREQ/UART_BPS=%0d must be >= 2", BPS_CNT);
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH=%0d must be a power of 2 >= 2", FIFO_DEPTH);
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;

  assign bus.tx_ready   = (level_q < LW'(FIFO_DEPTH));
  assign bus.fifo_level = level_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = done_q;
  assign bus.uart_txd   = txd_q;

  assign push = bus.tx_valid && bus.tx_ready;
  assign head = mem[rptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level_q != '0) pop = 1'b1;
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == DBIT_LAST) begin
            if (PAR_EN) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PAR: begin
        if (cnt_q == BIT_LAST) begin
          state_d = STOP;
          cnt_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == STOP_DONE) done_d = 1'b1;
        if (cnt_q == STOP_LAST) begin
          // A queued word chains straight into the next start bit.
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    if (pop) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = head;
      par_d   = PAR_ODD ? ~^head : ^head;
      txd_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the level counter guards every read.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wptr_q] <= bus.tx_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four builds (plain/depth 4, odd, even, 9-bit two-stop)
// share one clock; a frame-timeline model predicts the selected build every cycle.
module tb_uart_tx_fifo;
  localparam int CF   = 1000000;
  localparam int BPS  = 100000;
  localparam int N    = 10;
  localparam int LOGN = 8192;
  localparam int DB  [4] = '{8, 8, 8, 9};
  localparam int PR  [4] = '{0, 1, 2, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};
  localparam int DEP [4] = '{4, 16, 16, 16};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tv  = 1'b0;
  logic [8:0] tdat = '0;
  int         sel = 0;
  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_c ();
  uart_tx_fifo_if #(.DATA_BITS(9), .FIFO_DEPTH(16)) if_d ();

  assign if_a.tx_valid = tv && (sel == 0);
  assign if_b.tx_valid = tv && (sel == 1);
  assign if_c.tx_valid = tv && (sel == 2);
  assign if_d.tx_valid = tv && (sel == 3);
  assign if_a.tx_data  = tdat[7:0];
  assign if_b.tx_data  = tdat[7:0];
  assign if_c.tx_data  = tdat[7:0];
  assign if_d.tx_data  = tdat;

  uart_tx_fifo #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.sys_clk(clk), .sys_rst(rst), .bus(if_a.slave));
  uart_tx_fifo #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_b (.sys_clk(clk), .sys_rst(rst), .bus(if_b.slave));
  uart_tx_fifo #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_c (.sys_clk(clk), .sys_rst(rst), .bus(if_c.slave));
  uart_tx_fifo #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16))
    dut_d (.sys_clk(clk), .sys_rst(rst), .bus(if_d.slave));

  logic [3:0] txd_w, busy_w, done_w, rdy_w;
  logic [4:0] lvl_w [4];
  assign txd_w  = {if_d.uart_txd, if_c.uart_txd, if_b.uart_txd, if_a.uart_txd};
  assign busy_w = {if_d.busy, if_c.busy, if_b.busy, if_a.busy};
  assign done_w = {if_d.tx_done, if_c.tx_done, if_b.tx_done, if_a.tx_done};
  assign rdy_w  = {if_d.tx_ready, if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};
  assign lvl_w[0] = {2'b00, if_a.fifo_level};
  assign lvl_w[1] = if_b.fifo_level;
  assign lvl_w[2] = if_c.fifo_level;
  assign lvl_w[3] = if_d.fifo_level;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: a frame is a bit vector, each bit held N clocks. Frame k starts on the
  // edge max(handshake_k + 1, end of frame k-1); queued words wait in pend.
  logic [8:0]  pend [$];
  bit          act = 1'b0;
  int          cur_s = 0;
  int          flen = 0;
  logic [15:0] cur_bits = '1;
  bit          m_hs = 1'b0;
  int          m_last_hs = 0;

  initial forever begin
    logic [8:0] w;
    logic [8:0] mask;
    int         nb;
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
      act  = 1'b0;
      m_hs = 1'b0;
    end else begin
      mask = (DB[sel] == 9) ? 9'h1FF : 9'h0FF;
      m_hs = tv && (pend.size() < DEP[sel]);
      if (act && cyc == cur_s + flen * N) act = 1'b0;
      if (!act && pend.size() > 0) begin
        w = pend.pop_front();
        cur_bits    = '1;
        cur_bits[0] = 1'b0;
        for (int i = 0; i < DB[sel]; i++) cur_bits[1 + i] = w[i];
        nb = 1 + DB[sel];
        if (PR[sel] != 0) begin
          cur_bits[nb] = (PR[sel] == 1) ? ~^w : ^w;
          nb++;
        end
        flen  = nb + SB[sel];
        cur_s = cyc;
        act   = 1'b1;
      end
      if (m_hs) begin
        pend.push_back(tdat & mask);
        m_last_hs = cyc;
      end
    end
  end

  logic log_txd [LOGN];
  logic log_etxd [LOGN];
  logic log_busy [LOGN];
  logic log_done [LOGN];
  logic log_rdy [LOGN];
  logic [4:0] log_lvl [LOGN];

  // Compare process: every cycle out of reset, away from the rising edge.
  initial forever begin
    logic       e_txd, e_done, e_rdy;
    logic [4:0] e_lvl;
    @(negedge clk);
    e_txd  = act ? cur_bits[(cyc - cur_s) / N] : 1'b1;
    e_done = act && (cyc - cur_s == flen * N - 1);
    e_rdy  = pend.size() < DEP[sel];
    e_lvl  = 5'(pend.size());
    if (cyc < LOGN) begin
      log_txd[cyc]  = txd_w[sel];
      log_etxd[cyc] = e_txd;
      log_busy[cyc] = busy_w[sel];
      log_done[cyc] = done_w[sel];
      log_rdy[cyc]  = rdy_w[sel];
      log_lvl[cyc]  = lvl_w[sel];
    end
    if (!rst)
      chk("cycle_outputs{txd,busy,done,rdy,lvl}",
          32'({txd_w[sel], busy_w[sel], done_w[sel], rdy_w[sel], lvl_w[sel]}),
          32'({e_txd, act, e_done, e_rdy, e_lvl}));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int s);
    rst = 1'b1;
    sel = s;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic send(input logic [8:0] w);
    int t;
    tv   = 1'b1;
    tdat = w;
    t    = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (!m_hs && t < 2000);
    tv = 1'b0;
    chk("send_handshake", 32'(m_hs), 32'd1);
  endtask

  logic [8:0] rxq [$];
  task automatic decode(input int from, input int to, input int nd);
    logic [8:0] w;
    int i;
    rxq.delete();
    i = from;
    while (i < to && i + N * (nd + 2) < LOGN) begin
      if (log_txd[i] === 1'b0) begin
        w = '0;
        for (int b = 0; b < nd; b++) w[b] = log_txd[i + N / 2 + N * (1 + b)];
        rxq.push_back(w);
        i += N * (1 + nd) + N / 2;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int h, lows, highs, bz;
    logic [9:0] v, ev;
    logic [8:0] wr [6];

    // Reset state
    do_reset(0);
    chk("reset_state", 32'({if_a.uart_txd, if_a.busy, if_a.tx_done, if_a.tx_ready, if_a.fifo_level}),
        32'({1'b1, 1'b0, 1'b0, 1'b1, 3'd0}));

    // 0xA5, no parity, one stop bit
    send(9'h0A5);
    h = m_last_hs;
    wait_cyc(110);
    for (int k = 0; k < 10; k++) begin
      v[k]  = log_txd[h + 1 + N * k + 5];
      ev[k] = log_etxd[h + 1 + N * k + 5];
    end
    chk("a5_line", 32'(v), 32'(10'b1101001010));
    chk("a5_model_line", 32'(ev), 32'(10'b1101001010));
    chk("a5_idle_at_handshake", 32'(log_txd[h]), 32'd1);
    chk("a5_start_after_2_edges", 32'(log_txd[h + 1]), 32'd0);
    chk("a5_done_clk100", 32'(log_done[h + 100]), 32'd1);
    chk("a5_done_not_clk99", 32'(log_done[h + 99]), 32'd0);
    chk("a5_busy_clk100", 32'(log_busy[h + 100]), 32'd1);
    chk("a5_busy_fall", 32'(log_busy[h + 101]), 32'd0);

    // Odd parity, 0x03: two ones -> parity bit 1
    do_reset(1);
    send(9'h003);
    h = m_last_hs;
    wait_cyc(120);
    chk("odd_parity_bit", 32'(log_txd[h + 96]), 32'd1);
    chk("odd_stop_bit", 32'(log_txd[h + 106]), 32'd1);
    chk("odd_done_clk110", 32'(log_done[h + 110]), 32'd1);
    chk("odd_busy_fall", 32'(log_busy[h + 111]), 32'd0);

    // Even parity, 0x07: three ones -> parity bit 1 makes the total even
    do_reset(2);
    send(9'h007);
    h = m_last_hs;
    wait_cyc(120);
    chk("even_parity_bit", 32'(log_txd[h + 96]), 32'd1);
    chk("even_model_parity", 32'(log_etxd[h + 96]), 32'd1);
    chk("even_done_clk110", 32'(log_done[h + 110]), 32'd1);

    // Depth 4, six words with tx_valid held: backpressure and back-to-back frames
    do_reset(0);
    wr = '{9'h011, 9'h022, 9'h0C3, 9'h0F0, 9'h05A, 9'h0E7};
    send(wr[0]);
    h = m_last_hs;
    for (int i = 1; i < 6; i++) send(wr[i]);
    wait_cyc(h + 610 - cyc);
    chk("fifo_lvl_first_push", 32'(log_lvl[h]), 32'd1);
    chk("fifo_lvl_push_and_pop", 32'(log_lvl[h + 1]), 32'd1);
    chk("fifo_rdy_at_3", 32'(log_rdy[h + 3]), 32'd1);
    chk("fifo_full_lvl", 32'(log_lvl[h + 4]), 32'd4);
    chk("fifo_full_rdy", 32'(log_rdy[h + 4]), 32'd0);
    chk("fifo_rdy_after_pop", 32'(log_rdy[h + 101]), 32'd1);
    chk("fifo_refill_lvl", 32'(log_lvl[h + 102]), 32'd4);
    chk("b2b_stop_then_start", 32'({log_txd[h + 100], log_txd[h + 101]}), 32'(2'b10));
    bz = 0;
    for (int t = h + 1; t <= h + 600; t++) if (log_busy[t] === 1'b1) bz++;
    chk("b2b_busy_clocks", 32'(bz), 32'd600);
    chk("b2b_last_done", 32'(log_done[h + 600]), 32'd1);
    decode(h, h + 605, 8);
    chk("b2b_rx_count", 32'(rxq.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("b2b_rx_word", 32'((i < rxq.size()) ? rxq[i] : 9'h1AA), 32'(wr[i]));

    // Reset mid data bit 3 with a word still queued
    do_reset(0);
    send(9'h000);
    h = m_last_hs;
    send(9'h0FF);
    wait_cyc(h + 45 - cyc);
    chk("midrst_pre_txd", 32'(if_a.uart_txd), 32'd0);
    chk("midrst_pre_lvl", 32'(if_a.fifo_level), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_async", 32'({if_a.uart_txd, if_a.busy, if_a.tx_done, if_a.fifo_level}),
        32'({1'b1, 1'b0, 1'b0, 3'd0}));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    send(9'h03C);
    h = m_last_hs;
    wait_cyc(112);
    decode(h, h + 105, 8);
    chk("midrst_rx_count", 32'(rxq.size()), 32'd1);
    chk("midrst_rx_word", 32'((rxq.size() > 0) ? rxq[0] : 9'h1AA), 32'h03C);
    chk("midrst_done_clk100", 32'(log_done[h + 100]), 32'd1);

    // 9 data bits, two stop bits
    do_reset(3);
    send(9'h1FF);
    h = m_last_hs;
    wait_cyc(130);
    lows  = 0;
    highs = 0;
    for (int t = h + 1; t <= h + 120; t++) if (log_txd[t] === 1'b0) lows++;
    for (int t = h + 101; t <= h + 120; t++) if (log_txd[t] === 1'b1) highs++;
    chk("d9_low_clocks", 32'(lows), 32'd10);
    chk("d9_stop_high_clocks", 32'(highs), 32'd20);
    chk("d9_done_clk120", 32'({log_done[h + 119], log_done[h + 120]}), 32'(2'b01));
    chk("d9_busy_fall", 32'({log_busy[h + 120], log_busy[h + 121]}), 32'(2'b10));
    decode(h, h + 125, 9);
    chk("d9_rx_word", 32'((rxq.size() > 0) ? rxq[0] : 9'h0AA), 32'h1FF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
